seg7_scan_decoder: RTL

- Recovers hex digits from a multiplexed, active-low 4-digit seven-segment display bus: anode selects plus the a..g segment lines.
- Used as a loopback checker and capture block on the board display path.
- Samples the bus each clock and waits for each anode/segment pattern to hold stable, rejecting ghosting at scan transitions.
- Decodes each stable pattern back to a 4-bit value and holds the last good value per digit, with valid and error flags.

---
 rtl/seg7_scan_decoder_if.sv | 47 ++++
 rtl/seg7_scan_decoder.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/seg7_scan_decoder_if.sv
`default_nettype none
// ============================================================================
// Module   : seg7_scan_decoder_if
// Purpose  : Bundles the multiplexed seven-segment display bus (anode selects
//            and segment lines) with the decoded capture results of
//            seg7_scan_decoder.
// Signals  : an      [3:0]  digit selects, active-low, an[0] = digit 0
//            seg     [6:0]  segment lines {a,b,c,d,e,f,g}, active-low
//            digits  [15:0] decoded values, digit k in digits[4k+3:4k]
//            valid   [3:0]  per-digit "holds a good decoded value"
//            err     [3:0]  per-digit "last capture was unrecognised"
//            upd            one-cycle pulse on each capture
//            upd_idx [1:0]  digit index of the capture while upd=1
// Modports : master - drives the display bus, observes the results
//            slave  - the decoder: observes the bus, drives the results
// Revision : 1.0 - initial release
// ============================================================================
interface seg7_scan_decoder_if;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic [15:0] digits;
  logic [3:0]  valid;
  logic [3:0]  err;
  logic        upd;
  logic [1:0]  upd_idx;

  modport master (
    output an,
    output seg,
    input  digits,
    input  valid,
    input  err,
    input  upd,
    input  upd_idx
  );

  modport slave (
    input  an,
    input  seg,
    output digits,
    output valid,
    output err,
    output upd,
    output upd_idx
  );
endinterface
`default_nettype wire

// File: rtl/seg7_scan_decoder.sv
`default_nettype none
// ============================================================================
// Module   : seg7_scan_decoder
// Purpose  : Recovers hex digits from a multiplexed, active-low 4-digit
//            seven-segment display bus. Each clock the {an, seg} pair is
//            sampled; a pattern must hold for STABLE_CYCLES consecutive
//            clocks before it is captured, which rejects ghosting around
//            scan transitions. Captured patterns are decoded back to 4-bit
//            values and held per digit with valid/err flags.
// Ports    : clk  - system clock, rising edge
//            clr  - synchronous, active-high reset
//            bus  - seg7_scan_decoder_if.slave (an/seg in; digits, valid,
//                   err, upd, upd_idx out; all outputs registered)
// Params   : STABLE_CYCLES - consecutive identical samples needed (>= 1)
// Revision : 1.0 - initial release
// ============================================================================
module seg7_scan_decoder #(
  parameter int STABLE_CYCLES = 4
) (
  input  wire logic         clk,
  input  wire logic         clr,
  seg7_scan_decoder_if.slave bus
);

  // --------------------------------------------------------------------------
  // Constants
  // --------------------------------------------------------------------------
  localparam int                CNT_W      = $clog2(STABLE_CYCLES + 1);
  localparam logic [CNT_W-1:0] c_run_full = CNT_W'(STABLE_CYCLES);
  localparam logic [CNT_W-1:0] c_run_one  = CNT_W'(1);
  localparam int                SAMPLE_W   = 11;

  // --------------------------------------------------------------------------
  // Segment pattern decoder: returns {recognised, value}.
  // Patterns are {a,b,c,d,e,f,g}, active-low.
  // --------------------------------------------------------------------------
  function automatic logic [4:0] seg_decode(input logic [6:0] pat);
    logic [4:0] res;
    res = 5'b0_0000;
    case (pat)
      7'b0000001: res = 5'b1_0000;
      7'b1001111: res = 5'b1_0001;
      7'b0010010: res = 5'b1_0010;
      7'b0000110: res = 5'b1_0011;
      7'b1001100: res = 5'b1_0100;
      7'b0100100: res = 5'b1_0101;
      7'b0100000: res = 5'b1_0110;
      7'b0001111: res = 5'b1_0111;
      7'b0000000: res = 5'b1_1000;
      7'b0000100: res = 5'b1_1001;
      7'b0001000: res = 5'b1_1010;
      7'b1100000: res = 5'b1_1011;
      7'b0110001: res = 5'b1_1100;
      7'b1000010: res = 5'b1_1101;
      7'b0110000: res = 5'b1_1110;
      7'b0111000: res = 5'b1_1111;
      default:    res = 5'b0_0000;
    endcase
    return res;
  endfunction

  // --------------------------------------------------------------------------
  // Registered state
  // --------------------------------------------------------------------------
  logic [SAMPLE_W-1:0] r_prev;
  logic [CNT_W-1:0]    r_run;
  logic [15:0]         r_digits;
  logic [3:0]          r_valid;
  logic [3:0]          r_err;
  logic                r_upd;
  logic [1:0]          r_upd_idx;

  // --------------------------------------------------------------------------
  // Combinational sample qualification
  // --------------------------------------------------------------------------
  logic [SAMPLE_W-1:0] w_sample;
  logic                w_legal;
  logic [1:0]          w_idx;
  logic                w_same;
  logic [4:0]          w_dec;

  assign w_sample = {bus.an, bus.seg};
  assign w_same   = (w_sample == r_prev);
  assign w_dec    = seg_decode(bus.seg);

  // A sample is legal only with exactly one anode driven low; the position
  // of that low bit is the digit being shown.
  always_comb begin
    w_legal = 1'b0;
    w_idx   = 2'd0;
    case (bus.an)
      4'b1110: begin w_legal = 1'b1; w_idx = 2'd0; end
      4'b1101: begin w_legal = 1'b1; w_idx = 2'd1; end
      4'b1011: begin w_legal = 1'b1; w_idx = 2'd2; end
      4'b0111: begin w_legal = 1'b1; w_idx = 2'd3; end
      default: begin w_legal = 1'b0; w_idx = 2'd0; end
    endcase
  end

  // --------------------------------------------------------------------------
  // Run counter next value and capture strobe.
  // The counter saturates at STABLE_CYCLES, so the capture fires only on the
  // transition into the full count: a held pattern captures exactly once.
  // A changed legal sample restarts the run at 1, which with
  // STABLE_CYCLES=1 is itself the capture point.
  // --------------------------------------------------------------------------
  logic [CNT_W-1:0] w_run_next;
  logic             w_capture;

  always_comb begin
    w_run_next = '0;
    w_capture  = 1'b0;
    if (w_legal) begin
      if (!w_same) begin
        w_run_next = c_run_one;
        w_capture  = (c_run_one == c_run_full);
      end else if (r_run != c_run_full) begin
        w_run_next = r_run + c_run_one;
        w_capture  = (w_run_next == c_run_full);
      end else begin
        w_run_next = r_run;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Sample history and run counter. Clearing r_prev to zero on reset means
  // the first sample afterwards never matches (an=0000 is illegal), so a run
  // always restarts from 1 after clr.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (clr) begin
      r_prev <= '0;
      r_run  <= '0;
    end else begin
      r_prev <= w_sample;
      r_run  <= w_run_next;
    end
  end

  // --------------------------------------------------------------------------
  // Capture registers. Only the addressed digit is touched; an unrecognised
  // pattern keeps the old value but withdraws its valid flag.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (clr) begin
      r_digits  <= '0;
      r_valid   <= '0;
      r_err     <= '0;
      r_upd     <= 1'b0;
      r_upd_idx <= 2'd0;
    end else begin
      r_upd <= w_capture;
      if (w_capture) begin
        r_upd_idx <= w_idx;
        if (w_dec[4]) begin
          r_digits[{w_idx, 2'b00} +: 4] <= w_dec[3:0];
          r_valid[w_idx]                <= 1'b1;
          r_err[w_idx]                  <= 1'b0;
        end else begin
          r_valid[w_idx] <= 1'b0;
          r_err[w_idx]   <= 1'b1;
        end
      end
    end
  end

  // --------------------------------------------------------------------------
  // Outputs (all registered)
  // --------------------------------------------------------------------------
  assign bus.digits  = r_digits;
  assign bus.valid   = r_valid;
  assign bus.err     = r_err;
  assign bus.upd     = r_upd;
  assign bus.upd_idx = r_upd_idx;

endmodule
`default_nettype wire
